alu_result_fifo: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_result_fifo_if.sv | 30 +++
 rtl/alu_sat_counter.sv | 18 +
 rtl/alu_result_fifo.sv | 102 ++++++++++
 tb/tb_alu_result_fifo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, widths and the packed
// FIFO entry layout {flags, result} used downstream of the 8-bit ALU.
package alu_pkg;

   localparam int ALU_DATA_W  = 8;
   localparam int ALU_FLAGS_W = 4;

   // Flag bit positions inside the 4-bit flag vector.
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   // One stored ALU result: flags in the upper nibble, result below.
   typedef struct packed {
      logic [ALU_FLAGS_W-1:0] flags;
      logic [ALU_DATA_W-1:0]  result;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle around the ALU result FIFO.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; valid and its data stay stable
// until that edge, and ready never depends combinationally on valid.
// slave  : the FIFO (accepts in_*, presents out_*).
// master : the environment (ALU producer plus consumer).
interface alu_result_fifo_if
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_W-1:0]      in_result;
   logic [ALU_FLAGS_W-1:0] in_flags;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_W-1:0]      out_result;
   logic [ALU_FLAGS_W-1:0] out_flags;

   modport slave (
      input  in_valid, in_result, in_flags, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );

   modport master (
      output in_valid, in_result, in_flags, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/alu_sat_counter.sv
// 16-bit event counter that stops at all-ones instead of wrapping.
module alu_sat_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] value
);

   // Count enabled cycles, holding at 16'hFFFF once reached.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (en && (value != 16'hFFFF)) begin
         value <= value + 16'd1;
      end
   end

endmodule

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO capturing ALU results with their flags, plus a
// sticky register ORing all accepted flags since reset or clear.
// Optional build macro ALU_RESULT_FIFO_STATS_EN adds saturating push and
// stall counters (push_cnt, stall_cnt).
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_result_fifo_if.slave       bus,
   output logic [CNT_W-1:0]       count,
   output logic [ALU_FLAGS_W-1:0] sticky_flags,
   input  logic                   sticky_clr
`ifdef ALU_RESULT_FIFO_STATS_EN
   ,
   output logic [15:0]            push_cnt,
   output logic [15:0]            stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = ALU_FLAGS_W + DATA_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] head;

   // Ready and valid come only from the registered count, so a full FIFO
   // refuses a push even when the consumer pops in the same cycle.
   always_comb begin
      bus.in_ready  = (count != FULL_CNT);
      bus.out_valid = (count != '0);
      push          = bus.in_valid && bus.in_ready;
      pop           = bus.out_valid && bus.out_ready;
      head          = mem[rd_ptr];
      bus.out_result = '0;
      bus.out_flags  = '0;
      if (bus.out_valid) begin
         bus.out_result = head[DATA_W-1:0];
         bus.out_flags  = head[ENT_W-1:DATA_W];
      end
   end

   // Entry storage; deliberately not reset, only written on push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.in_flags, bus.in_result};
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Sticky flags: clear first, then OR in the flags being pushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_flags <= '0;
      end else begin
         sticky_flags <= (sticky_clr ? '0 : sticky_flags) |
                         (push ? bus.in_flags : '0);
      end
   end

`ifdef ALU_RESULT_FIFO_STATS_EN
   logic stall;
   assign stall = bus.in_valid && !bus.in_ready;

   alu_sat_counter u_push_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (push),
      .value (push_cnt)
   );

   alu_sat_counter u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (stall),
      .value (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based reference model.
module tb_alu_result_fifo;
   import alu_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] count;
   logic [3:0]       sticky_flags;
   logic             sticky_clr;
`ifdef ALU_RESULT_FIFO_STATS_EN
   logic [15:0]      push_cnt;
   logic [15:0]      stall_cnt;
`endif

   alu_result_fifo_if #(.DATA_W(8)) bus ();

   alu_result_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .count        (count),
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr)
`ifdef ALU_RESULT_FIFO_STATS_EN
      ,
      .push_cnt     (push_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   logic [11:0] exp_q[$];   // {flags, result} in arrival order
   logic [3:0]  exp_sticky;
   int          exp_push_cnt;
   int          exp_stall_cnt;
   int          n_checks;
   int          n_pass;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_sticky    = 4'h0;
      exp_push_cnt  = 0;
      exp_stall_cnt = 0;
   endtask

   task automatic check_outputs();
      logic [11:0] hd;
      hd = (exp_q.size() != 0) ? exp_q[0] : 12'h000;
      check_eq("out_valid", bus.out_valid, exp_q.size() != 0);
      check_eq("out_result", bus.out_result, hd[7:0]);
      check_eq("out_flags", bus.out_flags, hd[11:8]);
      check_eq("count", count, exp_q.size());
      check_eq("in_ready", bus.in_ready, exp_q.size() < DEPTH);
      check_eq("sticky", sticky_flags, exp_sticky);
`ifdef ALU_RESULT_FIFO_STATS_EN
      check_eq("push_cnt", push_cnt, exp_push_cnt);
      check_eq("stall_cnt", stall_cnt, exp_stall_cnt);
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_in(input logic v, input logic [7:0] r, input logic [3:0] f);
      bus.in_valid  = v;
      bus.in_result = r;
      bus.in_flags  = f;
   endtask

   // Check the current cycle, advance one clock, update the model.
   task automatic tick();
      logic        do_push;
      logic        do_pop;
      logic [11:0] ent;
      logic [11:0] dropped;
      check_outputs();
      do_push = bus.in_valid && (exp_q.size() < DEPTH);
      do_pop  = bus.out_ready && (exp_q.size() != 0);
      ent     = {bus.in_flags, bus.in_result};
      @(posedge clk);
      if (do_pop) dropped = exp_q.pop_front();
      if (do_push) exp_q.push_back(ent);
      exp_sticky = (sticky_clr ? 4'h0 : exp_sticky) | (do_push ? ent[11:8] : 4'h0);
      if (do_push && exp_push_cnt < 65535) exp_push_cnt++;
      if (bus.in_valid && !do_push && exp_stall_cnt < 65535) exp_stall_cnt++;
      @(negedge clk);
   endtask

   task automatic drain();
      set_in(1'b0, 8'h00, 4'h0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      bus.out_ready = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_reset();
      rst = 1'b1;
      sticky_clr = 1'b0;
      bus.out_ready = 1'b0;
      set_in(1'b0, 8'h00, 4'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick();
      tick();

      // In-order delivery with a stalled consumer.
      set_in(1'b1, 8'h10, 4'h0); tick();
      set_in(1'b1, 8'h0F, 4'h0); tick();
      set_in(1'b1, 8'hFF, 4'h8); tick();
      set_in(1'b0, 8'h00, 4'h0);
      check_eq("fill3_count", count, 3);
      check_eq("fill3_head", bus.out_result, 8'h10);
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check_eq("drain3_count", count, 0);
      bus.out_ready = 1'b0;

      // Full FIFO rejects a push even while popping.
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 8'(8'h20 + i), 4'h0);
         tick();
      end
      check_eq("full_count", count, DEPTH);
      set_in(1'b1, 8'hAA, 4'h0);
      bus.out_ready = 1'b1;
      check_eq("full_in_ready", bus.in_ready, 0);
      tick();
      bus.out_ready = 1'b0;
      check_eq("after_pop_count", count, 3);
      check_eq("after_pop_ready", bus.in_ready, 1);
      tick();
      check_eq("aa_accepted_count", count, 4);
      drain();

      // Streaming push+pop across pointer wrap.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_in(1'b1, 8'(i), 4'(i));
         tick();
         check_eq("stream_count", count, 1);
      end
      drain();

      // Sticky accumulation and clear-with-push.
      sticky_clr = 1'b1; set_in(1'b1, 8'h01, 4'h1); tick();
      sticky_clr = 1'b0; set_in(1'b1, 8'h02, 4'h4); tick();
      check_eq("sticky_acc", sticky_flags, 4'h5);
      sticky_clr = 1'b1; set_in(1'b1, 8'h03, 4'h2); tick();
      sticky_clr = 1'b0;
      check_eq("sticky_clr_push", sticky_flags, 4'h2);
      drain();

      // Asynchronous reset mid-stream.
      set_in(1'b1, 8'h55, 4'h3); tick();
      set_in(1'b1, 8'h66, 4'h1); tick();
      set_in(1'b0, 8'h00, 4'h0);
      check_eq("pre_rst_count", count, 2);
      #2 rst = 1'b1;
      #1;
      check_eq("async_out_valid", bus.out_valid, 0);
      check_eq("async_count", count, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check_eq("post_rst_ready", bus.in_ready, 1);
      tick();

`ifdef ALU_RESULT_FIFO_STATS_EN
      check_eq("stats_push_rst", push_cnt, 0);
      for (int i = 0; i < DEPTH; i++) begin
         set_in(1'b1, 8'(8'h40 + i), 4'h0);
         tick();
      end
      repeat (3) tick();
      check_eq("stats_stall3", stall_cnt, 3);
      check_eq("stats_push4", push_cnt, 4);
      drain();
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                4'($urandom_range(0, 15)));
         bus.out_ready = 1'($urandom_range(0, 2) != 0);
         sticky_clr    = ($urandom_range(0, 15) == 0);
         tick();
      end
      sticky_clr = 1'b0;
      drain();
      check_outputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
